// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC comb section.
// Slot fields are sized for the largest supported configuration; only the low bits are used.
package cic_pkg;

    localparam int unsigned DIFF_DELAY_MIN = 1;
    localparam int unsigned DIFF_DELAY_MAX = 2;

    localparam int unsigned DATA_W_MAX = 64;
    localparam int unsigned TID_W_MAX  = 16;

    function automatic int unsigned ch_width(input int unsigned channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [TID_W_MAX-1:0]  tid;
        logic [DATA_W_MAX-1:0] data;
`ifdef AXIS_CIC_COMB_TLAST_EN
        logic                  tlast;
`endif
    } slot_t;

endpackage

// File: rtl/cic_comb_stage.sv
// One comb stage: y[n] = x[n] - x[n-M] per channel, with per-channel M-deep delay lines.
// Only the low WIDTH data bits are meaningful; upper bits wrap harmlessly.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int unsigned DIFF_DELAY = 1,
    parameter int unsigned CHANNELS   = 1,
    parameter int unsigned CH_W       = 1
) (
    input  logic  aclk,
    input  logic  arst_n,
    input  logic  adv_i,
    input  slot_t slot_i,
    output slot_t slot_o
);

    logic [DATA_W_MAX-1:0] dly_q [CHANNELS][DIFF_DELAY];
    logic [CH_W-1:0]       ch;
    slot_t                 slot_d;
    slot_t                 slot_q;

    assign ch = slot_i.tid[CH_W-1:0];

    always_comb begin
        slot_d      = slot_i;
        slot_d.data = slot_i.data - dly_q[ch][DIFF_DELAY-1];
    end

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            slot_q <= '0;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                for (int m = 0; m < int'(DIFF_DELAY); m++) begin
                    dly_q[c][m] <= '0;
                end
            end
        end else if (adv_i) begin
            slot_q <= slot_d;
            // Bubbles pass through but must not disturb the channel history.
            if (slot_i.valid) begin
                dly_q[ch][0] <= slot_i.data;
                for (int m = 1; m < int'(DIFF_DELAY); m++) begin
                    dly_q[ch][m] <= dly_q[ch][m-1];
                end
            end
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/axis_cic_comb.sv
// N-stage pipelined CIC comb with AXI-Stream handshaking and time-interleaved channels.
// Define AXIS_CIC_COMB_TLAST_EN to carry tlast through the pipeline.
module axis_cic_comb
    import cic_pkg::*;
#(
    parameter int unsigned WIDTH      = 23,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned DIFF_DELAY = 1,
    parameter int unsigned CHANNELS   = 1,
    localparam int unsigned CH_W      = ch_width(CHANNELS)
) (
    input  logic             aclk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic [CH_W-1:0]  s_axis_tid,
`ifdef AXIS_CIC_COMB_TLAST_EN
    input  logic             s_axis_tlast,
    output logic             m_axis_tlast,
`endif
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic [CH_W-1:0]  m_axis_tid,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready
);

    logic  adv;
    slot_t in_slot;
    slot_t chain [STAGES+1];

    // Whole pipeline moves in lockstep; any stall at the output freezes every stage.
    assign adv           = ~m_axis_tvalid | m_axis_tready;
    assign s_axis_tready = adv;

    always_comb begin
        in_slot                  = '0;
        in_slot.valid            = s_axis_tvalid;
        in_slot.tid[CH_W-1:0]    = s_axis_tid;
        in_slot.data[WIDTH-1:0]  = s_axis_tdata;
`ifdef AXIS_CIC_COMB_TLAST_EN
        in_slot.tlast            = s_axis_tlast;
`endif
    end

    assign chain[0] = in_slot;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cic_comb_stage #(
            .DIFF_DELAY (DIFF_DELAY),
            .CHANNELS   (CHANNELS),
            .CH_W       (CH_W)
        ) u_stage (
            .aclk   (aclk),
            .arst_n (arst_n),
            .adv_i  (adv),
            .slot_i (chain[k]),
            .slot_o (chain[k+1])
        );
    end

    assign m_axis_tvalid = chain[STAGES].valid;
    assign m_axis_tdata  = chain[STAGES].data[WIDTH-1:0];
    assign m_axis_tid    = chain[STAGES].tid[CH_W-1:0];
`ifdef AXIS_CIC_COMB_TLAST_EN
    assign m_axis_tlast  = chain[STAGES].tlast;
`endif

    logic unused_out_slot;
    assign unused_out_slot = ^chain[STAGES];

`ifndef SYNTHESIS
    always_ff @(posedge aclk) begin
        if (arst_n) begin
            assert (DIFF_DELAY >= DIFF_DELAY_MIN && DIFF_DELAY <= DIFF_DELAY_MAX
                    && STAGES >= 1 && WIDTH <= DATA_W_MAX && CH_W <= TID_W_MAX)
                else $error("axis_cic_comb: unsupported parameterisation");
            if (s_axis_tvalid && s_axis_tready) begin
                assert (32'(s_axis_tid) < CHANNELS)
                    else $error("axis_cic_comb: s_axis_tid out of range");
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_cic_comb.sv
// Scoreboard bench: three comb configurations share one stimulus stream, each with its own model.
module tb_axis_cic_comb;

    localparam int NI = 3;
    localparam int NS [NI] = '{1, 3, 2};
    localparam int MD [NI] = '{1, 1, 2};

    logic          aclk = 1'b0;
    logic          arst_n;
    logic [7:0]    s_data;
    logic [1:0]    s_tid;
    logic          s_valid;
    logic          m_ready;
    logic [NI-1:0] s_ready;
    logic [NI-1:0] m_valid;
    logic [7:0]    m_data [NI];
    logic [1:0]    m_tid  [NI];
    logic [0:0]    m_tid_a;
    logic [0:0]    m_tid_b;

    always #5 aclk = ~aclk;

    axis_cic_comb #(.WIDTH(8), .STAGES(1), .DIFF_DELAY(1), .CHANNELS(2)) u_dut_a (
        .aclk(aclk), .arst_n(arst_n), .s_axis_tdata(s_data), .s_axis_tid(s_tid[0]),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready[0]), .m_axis_tdata(m_data[0]),
        .m_axis_tid(m_tid_a), .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready)
    );

    axis_cic_comb #(.WIDTH(8), .STAGES(3), .DIFF_DELAY(1), .CHANNELS(2)) u_dut_b (
        .aclk(aclk), .arst_n(arst_n), .s_axis_tdata(s_data), .s_axis_tid(s_tid[0]),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready[1]), .m_axis_tdata(m_data[1]),
        .m_axis_tid(m_tid_b), .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready)
    );

    axis_cic_comb #(.WIDTH(8), .STAGES(2), .DIFF_DELAY(2), .CHANNELS(3)) u_dut_c (
        .aclk(aclk), .arst_n(arst_n), .s_axis_tdata(s_data), .s_axis_tid(s_tid),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready[2]), .m_axis_tdata(m_data[2]),
        .m_axis_tid(m_tid[2]), .m_axis_tvalid(m_valid[2]), .m_axis_tready(m_ready)
    );

    assign m_tid[0] = {1'b0, m_tid_a};
    assign m_tid[1] = {1'b0, m_tid_b};

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: N-th order difference = sum_k (-1)^k C(N,k) x[n - kM].
    logic [7:0] hist    [NI][2][6];
    logic [9:0] exp_q   [NI][$];
    logic [9:0] out_log [NI][$];
    logic       hold    [NI];
    logic [9:0] hold_v  [NI];

    function automatic int binom(input int n, input int k);
        int r = 1;
        for (int j = 0; j < k; j++) r = r * (n - j) / (j + 1);
        return r;
    endfunction

    function automatic logic [7:0] model_out(input int i, input int c);
        int acc = 0;
        for (int k = 0; k <= NS[i]; k++) begin
            int term = binom(NS[i], k) * int'(hist[i][c][k*MD[i]]);
            acc = (k % 2 == 0) ? acc + term : acc - term;
        end
        return acc[7:0];
    endfunction

    always @(negedge aclk) begin
        for (int i = 0; i < NI; i++) begin
            if (!arst_n) begin
                exp_q[i].delete();
                hold[i] = 1'b0;
                for (int c = 0; c < 2; c++)
                    for (int j = 0; j < 6; j++) hist[i][c][j] = 8'h00;
                continue;
            end
            check_eq($sformatf("s_ready[%0d]", i), 32'(s_ready[i]), 32'(!m_valid[i] | m_ready));
            if (hold[i])
                check_eq($sformatf("stall_hold[%0d]", i), {21'd0, m_valid[i], m_tid[i], m_data[i]},
                         {21'd0, 1'b1, hold_v[i]});
            hold[i]   = m_valid[i] & ~m_ready;
            hold_v[i] = {m_tid[i], m_data[i]};
            if (m_valid[i] && m_ready) begin
                out_log[i].push_back({m_tid[i], m_data[i]});
                if (exp_q[i].size() == 0)
                    check_eq($sformatf("spurious_out[%0d]", i), 32'd1, 32'd0);
                else
                    check_eq($sformatf("out[%0d]", i), 32'({m_tid[i], m_data[i]}),
                             32'(exp_q[i].pop_front()));
            end
            if (s_valid && s_ready[i]) begin
                for (int j = 5; j > 0; j--) hist[i][s_tid[0]][j] = hist[i][s_tid[0]][j-1];
                hist[i][s_tid[0]][0] = s_data;
                exp_q[i].push_back({s_tid, model_out(i, int'(s_tid[0]))});
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [1:0] t);
        logic [NI-1:0] acc = '0;
        int n = 0;
        s_data  = d;
        s_tid   = t;
        s_valid = 1'b1;
        while (acc != '1 && n < 50) begin
            @(negedge aclk);
            acc |= s_ready;
            @(posedge aclk);
            #1;
            n++;
        end
        if (acc != '1) check_eq("accept_timeout", 32'(acc), 32'((1 << NI) - 1));
        s_valid = 1'b0;
    endtask

    task automatic reset_dut();
        arst_n = 1'b0;
        @(posedge aclk);
        #1;
        arst_n = 1'b1;
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("rst_m_valid[%0d]", i), 32'(m_valid[i]), 32'd0);
            check_eq($sformatf("rst_m_data[%0d]", i), 32'(m_data[i]), 32'd0);
            check_eq($sformatf("rst_m_tid[%0d]", i), 32'(m_tid[i]), 32'd0);
            check_eq($sformatf("rst_s_ready[%0d]", i), 32'(s_ready[i]), 32'd1);
            out_log[i].delete();
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 100) begin
            @(posedge aclk);
            #1;
            n++;
        end
        check_eq("drain", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);
    endtask

    task automatic expect_log(input int i, input int n, input logic [9:0] want [8]);
        check_eq($sformatf("log_len[%0d]", i), 32'(out_log[i].size()), 32'(n));
        for (int k = 0; k < n && k < out_log[i].size(); k++)
            check_eq($sformatf("log[%0d][%0d]", i, k), 32'(out_log[i][k]), 32'(want[k]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] want [8];
        int lat [NI];
        int cyc;

        arst_n  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_tid   = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        reset_dut();

        // Latency: output valid after STAGES advance edges.
        send(8'd9, 2'd0);
        lat = '{0, 0, 0};
        cyc = 1;
        while ((lat[0] == 0 || lat[1] == 0 || lat[2] == 0) && cyc <= 10) begin
            for (int i = 0; i < NI; i++) if (lat[i] == 0 && m_valid[i]) lat[i] = cyc;
            @(posedge aclk);
            #1;
            cyc++;
        end
        for (int i = 0; i < NI; i++) check_eq($sformatf("latency[%0d]", i), 32'(lat[i]), 32'(NS[i]));
        wait_drain();

        // Basic first difference.
        reset_dut();
        send(8'd5, 2'd0); send(8'd7, 2'd0); send(8'd7, 2'd0); send(8'd3, 2'd0);
        wait_drain();
        want = '{10'h005, 10'h002, 10'h000, 10'h0FC, 10'h0, 10'h0, 10'h0, 10'h0};
        expect_log(0, 4, want);

        // Impulse through three stages.
        reset_dut();
        send(8'd1, 2'd0);
        repeat (5) send(8'd0, 2'd0);
        wait_drain();
        want = '{10'h001, 10'h0FD, 10'h003, 10'h0FF, 10'h000, 10'h000, 10'h0, 10'h0};
        expect_log(1, 6, want);

        // Modular wrap, no saturation.
        reset_dut();
        send(8'h80, 2'd0); send(8'h7F, 2'd0);
        wait_drain();
        want = '{10'h080, 10'h0FF, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0};
        expect_log(0, 2, want);

        // Interleaved channels keep separate histories.
        reset_dut();
        send(8'd10, 2'd0); send(8'd100, 2'd1); send(8'd20, 2'd0); send(8'd50, 2'd1);
        wait_drain();
        want = '{10'h00A, 10'h164, 10'h00A, 10'h1CE, 10'h0, 10'h0, 10'h0, 10'h0};
        expect_log(0, 4, want);

        // Continuous stream with a 5-cycle downstream stall.
        reset_dut();
        fork
            for (int j = 0; j < 24; j++) send(8'(j * 7 + 3), 2'(j % 2));
            begin
                repeat (8) begin @(posedge aclk); #1; end
                m_ready = 1'b0;
                repeat (5) begin @(posedge aclk); #1; end
                m_ready = 1'b1;
            end
        join
        wait_drain();

        // Random backpressure.
        fork
            for (int j = 0; j < 30; j++) send(8'($urandom_range(0, 255)), 2'($urandom_range(0, 1)));
            repeat (60) begin
                @(posedge aclk);
                #1;
                m_ready = ($urandom_range(0, 3) != 0);
            end
        join
        m_ready = 1'b1;
        wait_drain();

        // Reset mid-stream discards in-flight samples and clears histories.
        for (int j = 0; j < 5; j++) send(8'(j + 60), 2'(j % 2));
        reset_dut();
        send(8'd40, 2'd0); send(8'hF9, 2'd1);
        wait_drain();
        want = '{10'h028, 10'h1F9, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0};
        expect_log(0, 2, want);

        repeat (3) @(posedge aclk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
